// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator controller: FSM state encodings and
// travel-direction constants.
package elevator_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE      = 2'd0;
  localparam state_t DOOR_OPEN = 2'd1;
  localparam state_t MOVING    = 2'd2;

  localparam logic UP   = 1'b1;
  localparam logic DOWN = 1'b0;

endpackage

// File: rtl/elevator_timer.sv
// Loadable down-counter; done is high whenever the count sits at zero.
// Used for both the per-floor travel time and the door dwell.
module elevator_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             done
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/elevator_ctrl.sv
// Single-car elevator controller: latches floor requests, sweeps in one
// direction while requests remain ahead, and dwells with the door open.
module elevator_ctrl
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS    = 8,
  parameter int DOOR_CYCLES   = 4,
  parameter int TRAVEL_CYCLES = 8,
  localparam int FLOOR_W      = (NUM_FLOORS > 1) ? $clog2(NUM_FLOORS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_FLOORS-1:0] sw,
  input  logic                  close,
  output logic [FLOOR_W-1:0]    floor,
  output logic                  dir,
  output logic                  door,
  output logic                  moving,
  output logic [NUM_FLOORS-1:0] pending
);

  localparam int TRAVEL_W = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
  localparam int DOOR_W   = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [FLOOR_W-1:0]    TOP_FLOOR = FLOOR_W'(NUM_FLOORS - 1);
  localparam logic [NUM_FLOORS-1:0] BIT0      = NUM_FLOORS'(1);

  state_t                  state, state_d;
  logic [FLOOR_W-1:0]      floor_d, next_floor;
  logic                    dir_d, can_step;
  logic [NUM_FLOORS-1:0]   pending_d, here_mask, next_mask, req;
  logic                    travel_load, travel_en, travel_done;
  logic                    dwell_load, dwell_en, dwell_done;

  // Keep heading the same way while anything lies ahead; turn only when
  // everything outstanding is behind. The end floors always point inward.
  function automatic logic pick_dir(input logic [FLOOR_W-1:0] f,
                                    input logic d,
                                    input logic [NUM_FLOORS-1:0] r);
    logic any_up, any_dn, nd;
    any_up = 1'b0;
    any_dn = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (r[i] && i > int'(f)) any_up = 1'b1;
      if (r[i] && i < int'(f)) any_dn = 1'b1;
    end
    nd = d;
    if (d == UP) begin
      if (!any_up && any_dn) nd = DOWN;
    end else begin
      if (!any_dn && any_up) nd = UP;
    end
    if (f == TOP_FLOOR) nd = DOWN;
    else if (f == '0)   nd = UP;
    return nd;
  endfunction

  assign can_step   = (dir == UP) ? (floor != TOP_FLOOR) : (floor != '0);
  assign next_floor = !can_step   ? floor :
                      (dir == UP) ? floor + FLOOR_W'(1) : floor - FLOOR_W'(1);
  assign here_mask  = BIT0 << floor;
  assign next_mask  = BIT0 << next_floor;

  // A call at the floor the car is parked at opens the door instead of latching.
  assign req = pending | ((state == MOVING) ? sw : (sw & ~here_mask));

  always_comb begin
    state_d     = state;
    floor_d     = floor;
    dir_d       = dir;
    pending_d   = req;
    travel_load = 1'b0;
    travel_en   = 1'b0;
    dwell_load  = 1'b0;
    dwell_en    = 1'b0;
    case (state)
      IDLE: begin
        if (sw[floor]) begin
          state_d    = DOOR_OPEN;
          dwell_load = 1'b1;
        end else if (req != '0) begin
          state_d     = MOVING;
          dir_d       = pick_dir(floor, dir, req);
          travel_load = 1'b1;
        end
      end
      DOOR_OPEN: begin
        if (sw[floor]) begin
          dwell_load = 1'b1;
        end else if (close || dwell_done) begin
          if (req != '0) begin
            state_d     = MOVING;
            dir_d       = pick_dir(floor, dir, req);
            travel_load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          dwell_en = 1'b1;
        end
      end
      MOVING: begin
        if (travel_done) begin
          floor_d   = next_floor;
          pending_d = req & ~next_mask;
          dir_d     = pick_dir(next_floor, dir, pending_d);
          if (req[next_floor]) begin
            state_d    = DOOR_OPEN;
            dwell_load = 1'b1;
          end else begin
            travel_load = 1'b1;
          end
        end else begin
          travel_en = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      floor   <= '0;
      dir     <= UP;
      pending <= '0;
    end else begin
      state   <= state_d;
      floor   <= floor_d;
      dir     <= dir_d;
      pending <= pending_d;
    end
  end

  // Loaded with N-1 so that each phase lasts exactly N cycles including the load edge.
  elevator_timer #(.WIDTH(TRAVEL_W)) u_travel (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (travel_load),
    .load_val (TRAVEL_W'(TRAVEL_CYCLES - 1)),
    .en       (travel_en),
    .done     (travel_done)
  );

  elevator_timer #(.WIDTH(DOOR_W)) u_dwell (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (dwell_load),
    .load_val (DOOR_W'(DOOR_CYCLES - 1)),
    .en       (dwell_en),
    .done     (dwell_done)
  );

  assign door   = (state == DOOR_OPEN);
  assign moving = (state == MOVING);

endmodule

// File: tb/tb_elevator_ctrl.sv
// Directed bench for elevator_ctrl with a cycle-level reference model of the
// car (position, elapsed phase time, request set) compared every cycle.
module tb_elevator_ctrl;

  localparam int NF = 8;
  localparam int DC = 4;
  localparam int TC = 8;

  logic          clk, rst_n, close;
  logic [NF-1:0] sw;
  logic [2:0]    floor;
  logic          dir, door, moving;
  logic [NF-1:0] pending;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    int      flr;
    int      elapsed;
    bit      dir;
    bit      door;
    bit      moving;
    bit [NF-1:0] pend;
  } model_t;

  model_t m;

  elevator_ctrl #(
    .NUM_FLOORS    (NF),
    .DOOR_CYCLES   (DC),
    .TRAVEL_CYCLES (TC)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sw      (sw),
    .close   (close),
    .floor   (floor),
    .dir     (dir),
    .door    (door),
    .moving  (moving),
    .pending (pending)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic model_t model_reset();
    model_t r;
    r = '0;
    r.dir = 1'b1;
    return r;
  endfunction

  // Head toward remaining calls ahead; reverse only when all are behind.
  function automatic bit model_dir(input int f, input bit d, input bit [NF-1:0] r);
    int n_up, n_dn;
    n_up = 0;
    n_dn = 0;
    for (int i = 0; i < NF; i++) begin
      if (r[i] && i > f) n_up++;
      if (r[i] && i < f) n_dn++;
    end
    if (f == NF - 1) return 1'b0;
    if (f == 0) return 1'b1;
    if (d && n_up == 0 && n_dn > 0) return 1'b0;
    if (!d && n_dn == 0 && n_up > 0) return 1'b1;
    return d;
  endfunction

  function automatic model_t model_next(input model_t cur, input logic [NF-1:0] s, input logic c);
    model_t n;
    bit [NF-1:0] r;
    n = cur;
    r = cur.pend | s;
    if (!cur.moving) r[cur.flr] = 1'b0;
    if (cur.moving) begin
      n.elapsed = cur.elapsed + 1;
      if (n.elapsed == TC) begin
        n.elapsed = 0;
        n.flr = cur.dir ? cur.flr + 1 : cur.flr - 1;
        if (r[n.flr]) begin
          r[n.flr] = 1'b0;
          n.moving = 1'b0;
          n.door   = 1'b1;
        end
        n.dir = model_dir(n.flr, cur.dir, r);
      end
    end else if (cur.door) begin
      if (s[cur.flr]) begin
        n.elapsed = 0;
      end else begin
        n.elapsed = cur.elapsed + 1;
        if (c || n.elapsed == DC) begin
          n.door    = 1'b0;
          n.elapsed = 0;
          if (r != '0) begin
            n.moving = 1'b1;
            n.dir    = model_dir(cur.flr, cur.dir, r);
          end
        end
      end
    end else begin
      if (s[cur.flr]) begin
        n.door    = 1'b1;
        n.elapsed = 0;
      end else if (r != '0) begin
        n.moving  = 1'b1;
        n.elapsed = 0;
        n.dir     = model_dir(cur.flr, cur.dir, r);
      end
    end
    n.pend = r;
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= model_reset();
    else        m <= model_next(m, sw, close);
  end

  task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One-cycle pulse of the request switches and close button.
  task automatic apply_stimulus(input logic [NF-1:0] s, input logic c);
    sw    = s;
    close = c;
    tick(1);
    sw    = '0;
    close = 1'b0;
  endtask

  task automatic wait_door(input int limit, input string name);
    int n;
    n = 0;
    while (door !== 1'b1 && n < limit) begin
      tick(1);
      n++;
    end
    check_output(name, 16'(door), 16'd1);
  endtask

  task automatic wait_closed(input int limit, input string name);
    int n;
    n = 0;
    while (door !== 1'b0 && n < limit) begin
      tick(1);
      n++;
    end
    check_output(name, 16'(door), 16'd0);
  endtask

  initial begin
    int bad_stops;
    rst_n = 1'b0;
    sw    = '0;
    close = 1'b0;
    tick(2);
    check_output("rst floor",   16'(floor),   16'd0);
    check_output("rst dir",     16'(dir),     16'd1);
    check_output("rst door",    16'(door),    16'd0);
    check_output("rst moving",  16'(moving),  16'd0);
    check_output("rst pending", 16'(pending), 16'd0);
    rst_n = 1'b1;

    fork
      forever begin
        @(negedge clk);
        check_output("model", {2'b0, 3'(m.flr), m.dir, m.door, m.moving, m.pend},
                              {2'b0, floor, dir, door, moving, pending});
        check_output("door_and_moving", 16'(door & moving), 16'd0);
      end
    join_none

    $display("[TB] single call to floor 3");
    apply_stimulus(8'h08, 1'b0);
    check_output("t1 moving", 16'(moving), 16'd1);
    check_output("t1 dir", 16'(dir), 16'd1);
    check_output("t1 pending", 16'(pending), 16'h08);
    tick(23);
    check_output("t1 floor before", 16'(floor), 16'd2);
    tick(1);
    check_output("t1 floor", 16'(floor), 16'd3);
    check_output("t1 door open", 16'(door), 16'd1);
    tick(3);
    check_output("t1 door dwell", 16'(door), 16'd1);
    tick(1);
    check_output("t1 door closed", 16'(door), 16'd0);
    check_output("t1 pending clear", 16'(pending), 16'd0);

    $display("[TB] calls at 1 and 5 from floor 3");
    apply_stimulus(8'h22, 1'b0);
    check_output("t2 dir up", 16'(dir), 16'd1);
    check_output("t2 pending", 16'(pending), 16'h22);
    tick(16);
    check_output("t2 stop 5", 16'(floor), 16'd5);
    check_output("t2 door 5", 16'(door), 16'd1);
    check_output("t2 dir down", 16'(dir), 16'd0);
    check_output("t2 pending 1", 16'(pending), 16'h02);
    bad_stops = 0;
    for (int k = 0; k < 36; k++) begin
      tick(1);
      if (door === 1'b1 && (floor == 3'd2 || floor == 3'd4)) bad_stops++;
    end
    check_output("t2 no stop 2/4", 16'(bad_stops), 16'd0);
    check_output("t2 stop 1", 16'(floor), 16'd1);
    check_output("t2 door 1", 16'(door), 16'd1);

    $display("[TB] close on second dwell cycle");
    tick(1);
    apply_stimulus(8'h00, 1'b1);
    check_output("t3 door closed", 16'(door), 16'd0);
    check_output("t3 idle", 16'(moving), 16'd0);
    apply_stimulus(8'h02, 1'b0);
    check_output("t3 reopen", 16'(door), 16'd1);
    apply_stimulus(8'h40, 1'b0);
    check_output("t3 pending 6", 16'(pending), 16'h40);
    apply_stimulus(8'h00, 1'b1);
    check_output("t3 close->move door", 16'(door), 16'd0);
    check_output("t3 close->move", 16'(moving), 16'd1);
    check_output("t3 dir up", 16'(dir), 16'd1);

    $display("[TB] call and close together during dwell");
    wait_door(100, "t4 arrive");
    check_output("t4 floor 6", 16'(floor), 16'd6);
    tick(1);
    apply_stimulus(8'h40, 1'b1);
    check_output("t4 held", 16'(door), 16'd1);
    tick(3);
    check_output("t4 held late", 16'(door), 16'd1);
    tick(1);
    check_output("t4 closed", 16'(door), 16'd0);
    check_output("t4 idle", 16'(moving), 16'd0);

    $display("[TB] top floor behaviour");
    apply_stimulus(8'h80, 1'b0);
    check_output("t5 up", 16'(dir), 16'd1);
    wait_door(100, "t5 arrive 7");
    check_output("t5 floor 7", 16'(floor), 16'd7);
    check_output("t5 dir forced", 16'(dir), 16'd0);
    wait_closed(20, "t5 closed");
    apply_stimulus(8'h80, 1'b0);
    check_output("t5 reopen", 16'(door), 16'd1);
    check_output("t5 no move", 16'(moving), 16'd0);
    check_output("t5 stay 7", 16'(floor), 16'd7);
    wait_closed(20, "t5 closed again");
    apply_stimulus(8'h01, 1'b0);
    check_output("t5 moving down", 16'(moving), 16'd1);
    check_output("t5 dir down", 16'(dir), 16'd0);
    tick(8);
    check_output("t5 floor 6", 16'(floor), 16'd6);

    $display("[TB] asynchronous reset mid-travel");
    tick(28);
    check_output("t6 floor 3", 16'(floor), 16'd3);
    check_output("t6 moving", 16'(moving), 16'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("t6 floor", 16'(floor), 16'd0);
    check_output("t6 door", 16'(door), 16'd0);
    check_output("t6 moving", 16'(moving), 16'd0);
    check_output("t6 pending", 16'(pending), 16'd0);
    check_output("t6 dir", 16'(dir), 16'd1);
    tick(1);
    rst_n = 1'b1;
    apply_stimulus(8'h04, 1'b0);
    check_output("t6 resume", 16'(moving), 16'd1);
    check_output("t6 resume pend", 16'(pending), 16'h04);
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
